// File: rtl/fifo_mac_pkg.sv
// Shared definitions for the fifo_mac dot-product engine: FSM encoding and
// the default datapath widths used across NPU stages.
package fifo_mac_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF  = 24;
    localparam int VEC_LEN_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_mac_mac_stage.sv
// mac_stage: registered signed multiply-accumulate with clear and enable.
// Clear has priority over accumulate; the running sum wraps modulo 2^ACC_WIDTH.
module mac_stage
    import fifo_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0]  acc_o
);

    logic signed [2*DATA_WIDTH-1:0] prod_s;
    logic signed [ACC_WIDTH-1:0]    prod_ext_s;
    logic [ACC_WIDTH-1:0]           acc_d;
    logic [ACC_WIDTH-1:0]           acc_q;

    assign prod_s     = (2*DATA_WIDTH)'($signed(a_i)) * (2*DATA_WIDTH)'($signed(b_i));
    assign prod_ext_s = ACC_WIDTH'(prod_s);
    assign acc_d      = acc_q + prod_ext_s;
    assign acc_o      = acc_q;

    // Accumulator register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fifo_mac.sv
// fifo_mac: pops VEC_LEN signed activations from the upstream FIFO, dots them
// with the internal weight bank and offers the sum on a valid/ready port.
module fifo_mac
    import fifo_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int VEC_LEN    = VEC_LEN_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int AW         = $clog2(VEC_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  start,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  w_wr_en,
    input  logic [AW-1:0]         w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy
);

    localparam int            CW        = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0] VEC_LEN_C = CW'(VEC_LEN);
    localparam logic [AW:0]   VEC_LEN_A = (AW + 1)'(VEC_LEN);

    state_e                state_q, state_d;
    logic [CW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         recv_q, recv_d;
    logic                  pending_q, pending_d;
    logic [ACC_WIDTH-1:0]  result_q, result_d;
    logic [DATA_WIDTH-1:0] weights_q [VEC_LEN];

    logic                  rd_en_s;
    logic                  clr_s;
    logic                  cap_s;
    logic                  w_we_s;
    logic [AW-1:0]         recv_idx_s;
    logic [ACC_WIDTH-1:0]  acc_s;

    assign recv_idx_s   = recv_q[AW-1:0];
    assign w_we_s       = w_wr_en && (state_q == ST_IDLE) && ({1'b0, w_addr} < VEC_LEN_A);
    assign fifo_rd_en   = rd_en_s;
    assign result       = result_q;
    assign result_valid = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);

    mac_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_s),
        .en_i  (cap_s),
        .a_i   (fifo_data),
        .b_i   (weights_q[recv_idx_s]),
        .acc_o (acc_s)
    );

    // Next-state, counter and pop-request logic
    always_comb begin
        state_d   = state_q;
        issued_d  = issued_q;
        recv_d    = recv_q;
        pending_d = pending_q;
        result_d  = result_q;
        rd_en_s   = 1'b0;
        clr_s     = 1'b0;
        cap_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && enable) begin
                    state_d   = ST_RUN;
                    issued_d  = '0;
                    recv_d    = '0;
                    pending_d = 1'b0;
                    clr_s     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                rd_en_s   = enable && !fifo_empty && (issued_q < VEC_LEN_C);
                pending_d = rd_en_s;
                // A pop issued last cycle always lands, whatever enable does now.
                cap_s     = pending_q;
                if (rd_en_s) begin
                    issued_d = issued_q + CW'(1);
                end else begin
                    issued_d = issued_q;
                end
                if (pending_q) begin
                    recv_d = recv_q + CW'(1);
                end else begin
                    recv_d = recv_q;
                end
                if (recv_q == VEC_LEN_C) begin
                    state_d  = ST_DONE;
                    result_d = acc_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            issued_q  <= '0;
            recv_q    <= '0;
            pending_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            issued_q  <= issued_d;
            recv_q    <= recv_d;
            pending_q <= pending_d;
            result_q  <= result_d;
        end
    end

    // Weight bank, writable only while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                weights_q[i] <= '0;
            end
        end else if (w_we_s) begin
            weights_q[w_addr] <= w_data;
        end
    end

endmodule
